// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - control inputs and measurement results of pwm_capture
interface pwm_capture_if #(
   parameter int CNT_WIDTH = 16
);
   logic                 enable;
   logic                 pwm_in;
   logic [CNT_WIDTH-1:0] high_time;
   logic [CNT_WIDTH-1:0] period;
   logic                 valid;
   logic                 timeout;
   logic                 level;

   modport master (
      output enable, pwm_in,
      input  high_time, period, valid, timeout, level
   );

   modport slave (
      input  enable, pwm_in,
      output high_time, period, valid, timeout, level
   );
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time and period measurement with timeout
module pwm_capture #(
   parameter int CNT_WIDTH = 16
) (
   input logic          clk,
   input logic          rst,
   pwm_capture_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HIGH = 2'd1;
   localparam logic [1:0] LOW  = 2'd2;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic                 s1, s2, s3;
   logic [1:0]           state;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] hi_cnt;
   logic [CNT_WIDTH-1:0] high_time_q;
   logic [CNT_WIDTH-1:0] period_q;
   logic                 valid_q;
   logic                 timeout_q;
   logic                 rise;
   logic                 fall;
   logic                 at_max;

   assign rise   = s2 & ~s3;
   assign fall   = ~s2 & s3;
   assign at_max = (cnt == CNT_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         s3          <= 1'b0;
         state       <= IDLE;
         cnt         <= '0;
         hi_cnt      <= '0;
         high_time_q <= '0;
         period_q    <= '0;
         valid_q     <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         s1        <= bus.pwm_in;
         s2        <= s1;
         s3        <= s2;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         if (!bus.enable) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (rise) begin
                     cnt   <= CNT_ONE;
                     state <= HIGH;
                  end
               end
               HIGH: begin
                  // a qualifying edge at saturation still wins over timeout
                  if (fall) begin
                     hi_cnt <= cnt;
                     cnt    <= cnt + CNT_ONE;
                     state  <= LOW;
                  end else if (at_max) begin
                     timeout_q <= 1'b1;
                     cnt       <= '0;
                     state     <= IDLE;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               LOW: begin
                  if (rise) begin
                     period_q    <= cnt;
                     high_time_q <= hi_cnt;
                     valid_q     <= 1'b1;
                     cnt         <= CNT_ONE;
                     state       <= HIGH;
                  end else if (at_max) begin
                     timeout_q <= 1'b1;
                     cnt       <= '0;
                     state     <= IDLE;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign bus.high_time = high_time_q;
   assign bus.period    = period_q;
   assign bus.valid     = valid_q;
   assign bus.timeout   = timeout_q;
   assign bus.level     = s2;
endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;
   localparam int W = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pwm_capture_if #(.CNT_WIDTH(W)) bus ();

   pwm_capture #(.CNT_WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   int edge_no = 0;
   int valid_cnt = 0;
   int timeout_cnt = 0;
   int both_cnt = 0;
   int last_valid_edge = 0;
   int prev_valid_edge = 0;
   int to_edge = 0;
   logic to_level = 1'b0;

   // Event recorder sampled 1 time unit after each active edge
   always @(posedge clk) begin
      edge_no++;
      #1;
      if (bus.valid) begin
         valid_cnt++;
         prev_valid_edge = last_valid_edge;
         last_valid_edge = edge_no;
      end
      if (bus.timeout) begin
         timeout_cnt++;
         to_edge  = edge_no;
         to_level = bus.level;
      end
      if (bus.valid && bus.timeout) both_cnt++;
   end

   task automatic run_pwm(input int h, input int l, input int n);
      for (int p = 0; p < n; p++) begin
         repeat (h) begin @(negedge clk); bus.pwm_in = 1'b1; end
         repeat (l) begin @(negedge clk); bus.pwm_in = 1'b0; end
      end
   endtask

   task automatic settle();
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      bus.enable = 1'b1;
      bus.pwm_in = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (bus.high_time !== 10'd0) $display("FAIL reset_high_time got %0d want 0", bus.high_time); else passed++;
      total++; if (bus.period !== 10'd0) $display("FAIL reset_period got %0d want 0", bus.period); else passed++;
      total++; if (bus.valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.valid); else passed++;
      total++; if (bus.timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", bus.timeout); else passed++;
      total++; if (bus.level !== 1'b0) $display("FAIL reset_level got %b want 0", bus.level); else passed++;
   endtask

   task automatic test_loopback();
      int v0 = valid_cnt;
      int t0 = timeout_cnt;
      run_pwm(64, 192, 4);
      total++; if (valid_cnt - v0 !== 3) $display("FAIL loop_valid_count got %0d want 3", valid_cnt - v0); else passed++;
      total++; if (bus.high_time !== 10'd64) $display("FAIL loop_high_time got %0d want 64", bus.high_time); else passed++;
      total++; if (bus.period !== 10'd256) $display("FAIL loop_period got %0d want 256", bus.period); else passed++;
      total++; if (last_valid_edge - prev_valid_edge !== 256) $display("FAIL loop_spacing got %0d want 256", last_valid_edge - prev_valid_edge); else passed++;
      total++; if (timeout_cnt - t0 !== 0) $display("FAIL loop_timeout got %0d want 0", timeout_cnt - t0); else passed++;
      settle();
   endtask

   task automatic test_duty_sweep();
      int duties[3] = '{1, 128, 255};
      for (int i = 0; i < 3; i++) begin
         int v0 = valid_cnt;
         run_pwm(duties[i], 256 - duties[i], 3);
         settle();
         total++; if (valid_cnt - v0 !== 3) $display("FAIL sweep%0d_valid_count got %0d want 3", duties[i], valid_cnt - v0); else passed++;
         total++; if (bus.high_time !== W'(duties[i])) $display("FAIL sweep%0d_high_time got %0d want %0d", duties[i], bus.high_time, duties[i]); else passed++;
         total++; if (bus.period !== 10'd256) $display("FAIL sweep%0d_period got %0d want 256", duties[i], bus.period); else passed++;
      end
   endtask

   task automatic test_min_pulse();
      int v0 = valid_cnt;
      run_pwm(1, 1, 4);
      settle();
      total++; if (valid_cnt - v0 !== 4) $display("FAIL min_valid_count got %0d want 4", valid_cnt - v0); else passed++;
      total++; if (bus.high_time !== 10'd1) $display("FAIL min_high_time got %0d want 1", bus.high_time); else passed++;
      total++; if (bus.period !== 10'd2) $display("FAIL min_period got %0d want 2", bus.period); else passed++;
   endtask

   task automatic test_latency();
      // previous period: 1 high, 1 low plus 4 settle cycles low -> 1/6
      @(negedge clk); bus.pwm_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++; if (bus.valid !== 1'b0) $display("FAIL lat_k1 got %b want 0", bus.valid); else passed++;
      @(negedge clk);
      total++; if (bus.valid !== 1'b1) $display("FAIL lat_k2 got %b want 1", bus.valid); else passed++;
      total++; if (bus.high_time !== 10'd1 || bus.period !== 10'd6) $display("FAIL lat_values got %0d/%0d want 1/6", bus.high_time, bus.period); else passed++;
      @(negedge clk);
      total++; if (bus.valid !== 1'b0) $display("FAIL lat_k3 got %b want 0", bus.valid); else passed++;
      repeat (59) begin @(negedge clk); bus.pwm_in = 1'b1; end
      repeat (192) begin @(negedge clk); bus.pwm_in = 1'b0; end
      run_pwm(64, 192, 2);
      total++; if (bus.high_time !== 10'd64 || bus.period !== 10'd256) $display("FAIL lat_relock got %0d/%0d want 64/256", bus.high_time, bus.period); else passed++;
   endtask

   task automatic test_timeout_high();
      int v0 = valid_cnt;
      int t0 = timeout_cnt;
      int k;
      @(negedge clk); bus.pwm_in = 1'b1;
      k = edge_no + 1;
      for (int c = 0; c < 1100 && timeout_cnt == t0; c++) @(negedge clk);
      total++; if (timeout_cnt - t0 !== 1) $display("FAIL toh_count got %0d want 1", timeout_cnt - t0); else passed++;
      total++; if (to_edge !== k + 1025) $display("FAIL toh_edge got %0d want %0d", to_edge, k + 1025); else passed++;
      total++; if (to_level !== 1'b1) $display("FAIL toh_level got %b want 1", to_level); else passed++;
      total++; if (valid_cnt - v0 !== 1) $display("FAIL toh_valid_count got %0d want 1", valid_cnt - v0); else passed++;
      total++; if (bus.high_time !== 10'd64 || bus.period !== 10'd256) $display("FAIL toh_hold got %0d/%0d want 64/256", bus.high_time, bus.period); else passed++;
      repeat (20) @(negedge clk);
      total++; if (timeout_cnt - t0 !== 1) $display("FAIL toh_single got %0d want 1", timeout_cnt - t0); else passed++;
   endtask

   task automatic test_timeout_low();
      int v0;
      int t0;
      int k;
      @(negedge clk); bus.pwm_in = 1'b0;
      repeat (20) @(negedge clk);
      v0 = valid_cnt;
      t0 = timeout_cnt;
      total++; if (timeout_cnt !== t0) $display("FAIL tol_idle_fall got %0d want %0d", timeout_cnt, t0); else passed++;
      @(negedge clk); bus.pwm_in = 1'b1;
      k = edge_no + 1;
      repeat (63) @(negedge clk);
      bus.pwm_in = 1'b0;
      for (int c = 0; c < 1100 && timeout_cnt == t0; c++) @(negedge clk);
      total++; if (timeout_cnt - t0 !== 1) $display("FAIL tol_count got %0d want 1", timeout_cnt - t0); else passed++;
      total++; if (to_edge !== k + 1025) $display("FAIL tol_edge got %0d want %0d", to_edge, k + 1025); else passed++;
      total++; if (to_level !== 1'b0) $display("FAIL tol_level got %b want 0", to_level); else passed++;
      total++; if (valid_cnt - v0 !== 0) $display("FAIL tol_valid_count got %0d want 0", valid_cnt - v0); else passed++;
      total++; if (bus.high_time !== 10'd64 || bus.period !== 10'd256) $display("FAIL tol_hold got %0d/%0d want 64/256", bus.high_time, bus.period); else passed++;
   endtask

   task automatic test_reset_mid();
      int v0 = valid_cnt;
      run_pwm(64, 192, 3);
      total++; if (valid_cnt - v0 !== 2) $display("FAIL rm_lock_count got %0d want 2", valid_cnt - v0); else passed++;
      repeat (10) begin @(negedge clk); bus.pwm_in = 1'b1; end
      @(negedge clk); rst = 1'b1; bus.pwm_in = 1'b0;
      @(negedge clk); rst = 1'b0;
      total++; if (bus.high_time !== 10'd0) $display("FAIL rm_high_time got %0d want 0", bus.high_time); else passed++;
      total++; if (bus.period !== 10'd0) $display("FAIL rm_period got %0d want 0", bus.period); else passed++;
      total++; if (bus.valid !== 1'b0) $display("FAIL rm_valid got %b want 0", bus.valid); else passed++;
      total++; if (bus.timeout !== 1'b0) $display("FAIL rm_timeout got %b want 0", bus.timeout); else passed++;
      total++; if (bus.level !== 1'b0) $display("FAIL rm_level got %b want 0", bus.level); else passed++;
      v0 = valid_cnt;
      run_pwm(64, 192, 2);
      settle();
      total++; if (valid_cnt - v0 !== 1) $display("FAIL rm_valid_count got %0d want 1", valid_cnt - v0); else passed++;
      total++; if (bus.high_time !== 10'd64) $display("FAIL rm_high_after got %0d want 64", bus.high_time); else passed++;
      total++; if (bus.period !== 10'd256) $display("FAIL rm_period_after got %0d want 256", bus.period); else passed++;
   endtask

   task automatic test_enable();
      int v0 = valid_cnt;
      int t0 = timeout_cnt;
      @(negedge clk); bus.enable = 1'b0;
      repeat (10) begin @(negedge clk); bus.pwm_in = 1'b1; end
      repeat (40) begin @(negedge clk); bus.pwm_in = 1'b0; end
      total++; if (valid_cnt - v0 !== 0) $display("FAIL en_valid_off got %0d want 0", valid_cnt - v0); else passed++;
      total++; if (timeout_cnt - t0 !== 0) $display("FAIL en_timeout_off got %0d want 0", timeout_cnt - t0); else passed++;
      total++; if (bus.high_time !== 10'd64) $display("FAIL en_hold_high got %0d want 64", bus.high_time); else passed++;
      total++; if (bus.period !== 10'd256) $display("FAIL en_hold_period got %0d want 256", bus.period); else passed++;
      @(negedge clk); bus.enable = 1'b1;
      v0 = valid_cnt;
      run_pwm(64, 192, 2);
      settle();
      total++; if (valid_cnt - v0 !== 1) $display("FAIL en_valid_count got %0d want 1", valid_cnt - v0); else passed++;
      total++; if (bus.high_time !== 10'd64 || bus.period !== 10'd256) $display("FAIL en_values got %0d/%0d want 64/256", bus.high_time, bus.period); else passed++;
   endtask

   initial begin
      bus.enable = 1'b1;
      bus.pwm_in = 1'b0;
      test_reset();
      test_loopback();
      test_duty_sweep();
      test_min_pulse();
      test_latency();
      test_timeout_high();
      test_timeout_low();
      test_reset_mid();
      test_enable();
      total++; if (both_cnt !== 0) $display("FAIL valid_timeout_overlap got %0d want 0", both_cnt); else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
